// File: rtl/reg_file_read_port.sv
// Sixteen-entry register file with three registered read ports, one write
// port, instruction-field address resolution and write-through forwarding.
module reg_file_read_port #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [15:0]   instr,
  input  logic          ReadRegSrc1,
  input  logic          ReadRegSrc2,
  input  logic          ReadRegSrc3,
  input  logic          ReadRegSrc4,
  input  logic          we,
  input  logic [3:0]    wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] rdata3,
  output logic [3:0]    raddr1,
  output logic [3:0]    raddr2,
  output logic          rvalid
);

  localparam int unsigned AW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t         state_q;
  logic [DW-1:0]  regs_q [NREG];
  logic [DW-1:0]  rdata1_q, rdata2_q, rdata3_q;
  logic [DW-1:0]  rdata1_d, rdata2_d, rdata3_d;
  logic [AW-1:0]  raddr1_q, raddr2_q;
  logic [AW-1:0]  raddr1_d, raddr2_d, raddr3_d;
  logic           rvalid_q;
  logic           sel1, sel2, sel3, sel4;

  // Opcode field is not needed to resolve operands.
  logic unused_opcode;
  assign unused_opcode = ^instr[15:12];

  // Register value with same-cycle write forwarding; r0 is hard-wired zero.
  function automatic logic [DW-1:0] fwd_value(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == '0) begin
      v = '0;
    end else if (we && (wa == a)) begin
      v = wd;
    end else begin
      v = regs_q[a];
    end
    return v;
  endfunction

  // Decode selects (only a definite 1 counts) and resolve operand sources.
  always_comb begin
    sel1 = 1'b0;
    sel2 = 1'b0;
    sel3 = 1'b0;
    sel4 = 1'b0;
    if (ReadRegSrc1 == 1'b1) sel1 = 1'b1;
    if (ReadRegSrc2 == 1'b1) sel2 = 1'b1;
    if (ReadRegSrc3 == 1'b1) sel3 = 1'b1;
    if (ReadRegSrc4 == 1'b1) sel4 = 1'b1;

    raddr1_d = sel1 ? instr[11:8] : instr[7:4];
    raddr2_d = sel2 ? instr[11:8] : instr[3:0];
    raddr3_d = instr[7:4];

    rdata1_d = fwd_value(raddr1_d);
    rdata2_d = sel4 ? DW'(instr[3:0]) : fwd_value(raddr2_d);
    rdata3_d = sel3 ? fwd_value(raddr3_d) : '0;
  end

  // Storage write port; r0 writes are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  // Two-state read control with registered operands, addresses and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rdata3_q <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_en) begin
            state_q  <= VALID;
            rvalid_q <= 1'b1;
          end else begin
            rvalid_q <= 1'b0;
          end
        end
        VALID: begin
          if (rd_en) begin
            rvalid_q <= 1'b1;
          end else begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
      if (rd_en) begin
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
        rdata3_q <= rdata3_d;
        raddr1_q <= raddr1_d;
        raddr2_q <= raddr2_d;
      end
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;
  assign rdata3 = rdata3_q;
  assign raddr1 = raddr1_q;
  assign raddr2 = raddr2_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_reg_file_read_port.sv
// Bench for reg_file_read_port: behavioural model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_reg_file_read_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] instr = '0;
  logic        ReadRegSrc1 = 1'b0, ReadRegSrc2 = 1'b0;
  logic        ReadRegSrc3 = 1'b0, ReadRegSrc4 = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [15:0] wd = '0;
  logic [15:0] rdata1, rdata2, rdata3;
  logic [3:0]  raddr1, raddr2;
  logic        rvalid;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  reg_file_read_port #(.DW(16), .NREG(16)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .instr(instr),
    .ReadRegSrc1(ReadRegSrc1), .ReadRegSrc2(ReadRegSrc2),
    .ReadRegSrc3(ReadRegSrc3), .ReadRegSrc4(ReadRegSrc4),
    .we(we), .wa(wa), .wd(wd),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .raddr1(raddr1), .raddr2(raddr2), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  // Model state: register contents and the operands the outputs must show.
  logic [15:0] m_reg [16];
  logic [15:0] e_rd1 = '0, e_rd2 = '0, e_rd3 = '0;
  logic [3:0]  e_ra1 = '0, e_ra2 = '0;
  logic        e_val = 1'b0;

  initial for (int i = 0; i < 16; i++) m_reg[i] = '0;

  function automatic logic [15:0] m_val(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (we && wa == a) return wd;
    return m_reg[a];
  endfunction

  // Apply the register-file rules at each rising edge.
  always @(posedge clk) begin
    logic [3:0] a1, a2;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      e_rd1 = '0; e_rd2 = '0; e_rd3 = '0; e_ra1 = '0; e_ra2 = '0; e_val = 1'b0;
    end else begin
      if (rd_en) begin
        a1 = ReadRegSrc1 ? instr[11:8] : instr[7:4];
        a2 = ReadRegSrc2 ? instr[11:8] : instr[3:0];
        e_rd1 = m_val(a1);
        e_rd2 = ReadRegSrc4 ? {12'h000, instr[3:0]} : m_val(a2);
        e_rd3 = ReadRegSrc3 ? m_val(instr[7:4]) : 16'h0000;
        e_ra1 = a1;
        e_ra2 = a2;
        e_val = 1'b1;
      end else begin
        e_val = 1'b0;
      end
      if (we && wa != 4'd0) m_reg[wa] = wd;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rdata1", rdata1, e_rd1);
      chk("m_rdata2", rdata2, e_rd2);
      chk("m_rdata3", rdata3, e_rd3);
      chk("m_raddr1", 16'(raddr1), 16'(e_ra1));
      chk("m_raddr2", 16'(raddr2), 16'(e_ra2));
      chk("m_rvalid", 16'(rvalid), 16'(e_val));
    end
  end

  task automatic step(input logic rst, input logic rde, input logic [15:0] ins,
                      input logic [3:0] sel, input logic w, input logic [3:0] a,
                      input logic [15:0] d);
    reset = rst; rd_en = rde; instr = ins;
    ReadRegSrc1 = sel[0]; ReadRegSrc2 = sel[1];
    ReadRegSrc3 = sel[2]; ReadRegSrc4 = sel[3];
    we = w; wa = a; wd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1, a, d);
  endtask

  initial begin
    // Reset with a write pending: it must be dropped.
    step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 4'd3, 16'hBEEF);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 4'd3, 16'hBEEF);
    chk("rst_rdata1", rdata1, 16'h0000);
    chk("rst_rdata2", rdata2, 16'h0000);
    chk("rst_rdata3", rdata3, 16'h0000);
    chk("rst_rvalid", 16'(rvalid), 16'h0000);
    step(1'b0, 1'b1, 16'h0030, 4'b0000, 1'b0, 4'd0, 16'h0000);
    chk("post_rst_rdata1", rdata1, 16'h0000);
    chk("post_rst_rdata2", rdata2, 16'h0000);
    chk("post_rst_rvalid", 16'(rvalid), 16'h0001);
    chk("post_rst_raddr1", 16'(raddr1), 16'h0003);

    // Select resolution.
    wr(4'd5, 16'h1111);
    wr(4'd6, 16'h2222);
    wr(4'd7, 16'h3333);
    step(1'b0, 1'b1, 16'h1567, 4'b0101, 1'b0, 4'd0, 16'h0000);
    chk("sel_rdata1", rdata1, 16'h1111);
    chk("sel_rdata2", rdata2, 16'h3333);
    chk("sel_rdata3", rdata3, 16'h2222);
    chk("sel_raddr1", 16'(raddr1), 16'h0005);
    chk("sel_raddr2", 16'(raddr2), 16'h0007);

    // Shift immediate replaces port-2 data but not its address.
    wr(4'd9, 16'hFFFF);
    step(1'b0, 1'b1, 16'h0249, 4'b1000, 1'b0, 4'd0, 16'h0000);
    chk("shamt_rdata2", rdata2, 16'h0009);
    chk("shamt_raddr2", 16'(raddr2), 16'h0009);

    // Same-cycle write forwarding, then the stored value.
    step(1'b0, 1'b1, 16'h0044, 4'b0000, 1'b1, 4'd4, 16'hA5A5);
    chk("fwd_rdata1", rdata1, 16'hA5A5);
    chk("fwd_rdata2", rdata2, 16'hA5A5);
    step(1'b0, 1'b1, 16'h0044, 4'b0000, 1'b0, 4'd0, 16'h0000);
    chk("stored_rdata1", rdata1, 16'hA5A5);

    // r0 immutability.
    wr(4'd0, 16'h1234);
    step(1'b0, 1'b1, 16'h0000, 4'b0100, 1'b1, 4'd0, 16'h5555);
    chk("r0_rdata1", rdata1, 16'h0000);
    chk("r0_rdata3", rdata3, 16'h0000);

    // Handshake 1,1,0,1 with reset on the fourth cycle.
    step(1'b0, 1'b1, 16'h0567, 4'b0000, 1'b0, 4'd0, 16'h0000);
    chk("hs1_rvalid", 16'(rvalid), 16'h0001);
    chk("hs1_rdata1", rdata1, 16'h2222);
    step(1'b0, 1'b1, 16'h0056, 4'b0000, 1'b0, 4'd0, 16'h0000);
    chk("hs2_rvalid", 16'(rvalid), 16'h0001);
    chk("hs2_rdata2", rdata2, 16'h2222);
    step(1'b0, 1'b0, 16'h0099, 4'b0111, 1'b0, 4'd0, 16'h0000);
    chk("hs3_rvalid", 16'(rvalid), 16'h0000);
    chk("hs3_hold_rdata1", rdata1, 16'h1111);
    chk("hs3_hold_raddr2", 16'(raddr2), 16'h0006);
    step(1'b1, 1'b1, 16'h0056, 4'b0000, 1'b1, 4'd5, 16'h7777);
    chk("hs4_rvalid", 16'(rvalid), 16'h0000);
    chk("hs4_rdata1", rdata1, 16'h0000);
    step(1'b0, 1'b1, 16'h0056, 4'b0100, 1'b0, 4'd0, 16'h0000);
    chk("after_rst_rdata1", rdata1, 16'h0000);
    chk("after_rst_rdata3", rdata3, 16'h0000);

    // Sweep of addresses and selects with concurrent writes, model-checked.
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(i * 16'h0101) ^ 16'h8000);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, (i % 5) != 4,
           {4'h0, 4'(i), 4'(i + 3), 4'(15 - i)},
           4'(i * 7), (i % 3) == 0, 4'(i + 3), 16'(i * 16'h1357));
    end

    step(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd0, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
